// File: rtl/image_compare_ctrl_if.sv
// Shared read bus between the compare controller and the two image memories.
// The controller drives the shared address; each memory returns its own pixel.
interface image_compare_ctrl_if #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 16
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem0_dout;
   logic [DATA_W-1:0] mem1_dout;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem0_dout,
      input  mem1_dout
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem0_dout,
      output mem1_dout
   );
endinterface

// File: rtl/image_compare_ctrl.sv
// Raster sweep of two pixel memories with tolerance compare, saturating
// mismatch count and first-mismatch capture.
module image_compare_ctrl #(
   parameter int DATA_W = 12,
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [DATA_W-1:0]   tol,
   image_compare_ctrl_if.master mem,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [CNT_W-1:0]    mismatch_cnt,
   output logic                first_err_valid,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic [15:0]         first_err_row,
   output logic [15:0]         first_err_col
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [15:0]       COL_LAST  = 16'(IMG_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state_q;
   state_t            state_d;
   logic              rd_en;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       row_q;
   logic [15:0]       col_q;
   logic              v_q;
   logic [ADDR_W-1:0] d_addr;
   logic [15:0]       d_row;
   logic [15:0]       d_col;
   logic [DATA_W-1:0] tol_q;
   logic [DATA_W-1:0] diff;
   logic              hit;
   logic [CNT_W-1:0]  cnt_nxt;

   assign mem.mem_rd_en = rd_en;
   assign mem.mem_addr  = addr_q;

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (abort) state_d = IDLE;
            else if (addr_q == LAST_ADDR) state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (abort) state_d = IDLE;
            else state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Compare-then-subtract keeps |a-b| exact without a sign bit.
   always_comb begin
      if (mem.mem0_dout > mem.mem1_dout) diff = mem.mem0_dout - mem.mem1_dout;
      else diff = mem.mem1_dout - mem.mem0_dout;
      hit     = v_q & ~abort & (diff > tol_q);
      cnt_nxt = mismatch_cnt;
      if (hit && mismatch_cnt != CNT_MAX) cnt_nxt = mismatch_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q          <= '0;
         row_q           <= '0;
         col_q           <= '0;
         v_q             <= 1'b0;
         d_addr          <= '0;
         d_row           <= '0;
         d_col           <= '0;
         tol_q           <= '0;
         pass            <= 1'b0;
         mismatch_cnt    <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
         first_err_row   <= '0;
         first_err_col   <= '0;
      end else begin
         // Abort drops the read issued this cycle so it is never compared.
         v_q    <= rd_en & ~abort;
         d_addr <= addr_q;
         d_row  <= row_q;
         d_col  <= col_q;

         mismatch_cnt <= cnt_nxt;
         if (hit && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= d_addr;
            first_err_row   <= d_row;
            first_err_col   <= d_col;
         end

         if (state_q == IDLE && start) begin
            tol_q           <= tol;
            addr_q          <= '0;
            row_q           <= '0;
            col_q           <= '0;
            pass            <= 1'b0;
            mismatch_cnt    <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_row   <= '0;
            first_err_col   <= '0;
         end

         if (state_q == RUN && !abort && addr_q != LAST_ADDR) begin
            addr_q <= addr_q + 1'b1;
            if (col_q == COL_LAST) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end

         if (state_q == DRAIN && !abort) pass <= (cnt_nxt == '0);
      end
   end

endmodule

// File: tb/tb_image_compare_ctrl.sv
// Randomized self-check of image_compare_ctrl on a 4x3 image against a
// plain-arithmetic model; a second instance exercises counter saturation.
module tb_image_compare_ctrl;

   localparam int DW = 12;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int AW = 8;
   localparam int N  = W * H;

   logic clk = 1'b0;
   logic rst, start, abort;
   logic [DW-1:0] tol;

   always #5 clk = ~clk;

   image_compare_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();
   image_compare_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) mif_s ();

   logic          busy, done, pass, fev;
   logic [15:0]   cnt;
   logic [AW-1:0] fea;
   logic [15:0]   frow, fcol;
   logic          busy_s, done_s, pass_s, fev_s;
   logic [1:0]    cnt_s;
   logic [AW-1:0] fea_s;
   logic [15:0]   frow_s, fcol_s;

   image_compare_ctrl #(
      .DATA_W(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .tol(tol),
      .mem(mif.master), .busy(busy), .done(done), .pass(pass),
      .mismatch_cnt(cnt), .first_err_valid(fev), .first_err_addr(fea),
      .first_err_row(frow), .first_err_col(fcol)
   );

   image_compare_ctrl #(
      .DATA_W(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CNT_W(2)
   ) dut_s (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .tol(tol),
      .mem(mif_s.master), .busy(busy_s), .done(done_s), .pass(pass_s),
      .mismatch_cnt(cnt_s), .first_err_valid(fev_s), .first_err_addr(fea_s),
      .first_err_row(frow_s), .first_err_col(fcol_s)
   );

   logic [DW-1:0] m0 [N];
   logic [DW-1:0] m1 [N];

   always @(posedge clk) begin
      if (mif.mem_rd_en && int'(mif.mem_addr) < N) begin
         mif.mem0_dout <= m0[mif.mem_addr];
         mif.mem1_dout <= m1[mif.mem_addr];
      end
      if (mif_s.mem_rd_en && int'(mif_s.mem_addr) < N) begin
         mif_s.mem0_dout <= m0[mif_s.mem_addr];
         mif_s.mem1_dout <= m1[mif_s.mem_addr];
      end
   end

   int n_vec = 0;
   int n_err = 0;

   int e_cnt, e_cnt_s, e_fea, e_row, e_col;
   bit e_fev;

   int   obs_addr [1:20];
   logic obs_en   [1:20];
   logic obs_busy [1:20];
   int   obs_cnt  [1:20];
   logic obs_fev  [1:20];
   int   done_cyc, n_done;
   logic done_pass, done_pass_s;

   task automatic model(input logic [DW-1:0] t);
      e_cnt = 0; e_fev = 0; e_fea = 0; e_row = 0; e_col = 0;
      for (int i = 0; i < N; i++) begin
         int a, b, d;
         a = int'(m0[i]);
         b = int'(m1[i]);
         d = (a > b) ? a - b : b - a;
         if (d > int'(t)) begin
            if (!e_fev) begin
               e_fev = 1; e_fea = i; e_row = i / W; e_col = i % W;
            end
            e_cnt++;
         end
      end
      e_cnt_s = (e_cnt > 3) ? 3 : e_cnt;
   endtask

   task automatic fill_same();
      for (int i = 0; i < N; i++) begin
         m0[i] = DW'($urandom);
         m1[i] = m0[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_seq(input logic [DW-1:0] t, input int abort_cyc,
                          input int restart_cyc, input int rst_cyc,
                          input bit scramble);
      tol = t;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (scramble) tol = DW'($urandom);
      n_done = 0; done_cyc = -1; done_pass = 1'b0; done_pass_s = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         obs_addr[k] = int'(mif.mem_addr);
         obs_en[k]   = mif.mem_rd_en;
         obs_busy[k] = busy;
         obs_cnt[k]  = int'(cnt);
         obs_fev[k]  = fev;
         if (done) begin
            n_done++; done_cyc = k; done_pass = pass; done_pass_s = pass_s;
         end
         abort = (k == abort_cyc);
         start = (k == restart_cyc);
         rst   = (k == rst_cyc);
         tick();
         abort = 1'b0; start = 1'b0; rst = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; tol = '0;
      tick(); tick();
      rst = 1'b0;
      n_vec++;
      if ({busy, done, pass, fev, mif.mem_rd_en} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags got %b want 00000",
                  {busy, done, pass, fev, mif.mem_rd_en});
      end
      n_vec++;
      if ({cnt, fea, frow, fcol, mif.mem_addr} !== '0) begin
         n_err++;
         $display("FAIL reset_values cnt=%0d addr=%0d fea=%0d want all 0",
                  cnt, mif.mem_addr, fea);
      end
   endtask

   task automatic test_identical();
      int bad;
      fill_same();
      run_seq(12'h000, 0, 0, 0, 0);
      bad = 0;
      for (int k = 1; k <= 12; k++)
         if (obs_addr[k] !== k - 1 || obs_en[k] !== 1'b1) bad++;
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL ident_addr_seq got %0d bad cycles want 0", bad);
      end
      n_vec++;
      if (obs_en[13] !== 1'b0 || obs_busy[13] !== 1'b1 || obs_addr[13] !== 11) begin
         n_err++;
         $display("FAIL ident_drain en=%b busy=%b addr=%0d want 0 1 11",
                  obs_en[13], obs_busy[13], obs_addr[13]);
      end
      n_vec++;
      if (done_cyc !== 14 || n_done !== 1) begin
         n_err++;
         $display("FAIL ident_done cyc=%0d pulses=%0d want 14 1", done_cyc, n_done);
      end
      n_vec++;
      if (done_pass !== 1'b1 || cnt !== 16'd0 || fev !== 1'b0 || obs_busy[15] !== 1'b0) begin
         n_err++;
         $display("FAIL ident_result pass=%b cnt=%0d fev=%b busy15=%b want 1 0 0 0",
                  done_pass, cnt, fev, obs_busy[15]);
      end
   endtask

   task automatic test_single();
      fill_same();
      m0[5] = 12'h100; m1[5] = 12'h101;
      run_seq(12'h000, 0, 0, 0, 0);
      n_vec++;
      if (cnt !== 16'd1 || pass !== 1'b0 || fev !== 1'b1) begin
         n_err++;
         $display("FAIL single_cnt cnt=%0d pass=%b fev=%b want 1 0 1", cnt, pass, fev);
      end
      n_vec++;
      if (fea !== 8'd5 || frow !== 16'd1 || fcol !== 16'd1) begin
         n_err++;
         $display("FAIL single_loc addr=%0d row=%0d col=%0d want 5 1 1", fea, frow, fcol);
      end
   endtask

   task automatic test_tolerance();
      fill_same();
      m0[5] = 12'h100; m1[5] = 12'h101;
      run_seq(12'h001, 0, 0, 0, 0);
      n_vec++;
      if (done_pass !== 1'b1 || cnt !== 16'd0) begin
         n_err++;
         $display("FAIL tol_within pass=%b cnt=%0d want 1 0", done_pass, cnt);
      end
      m0[5] = 12'h102; m1[5] = 12'h100;
      run_seq(12'h001, 0, 0, 0, 0);
      n_vec++;
      if (cnt !== 16'd1 || done_pass !== 1'b0) begin
         n_err++;
         $display("FAIL tol_over cnt=%0d pass=%b want 1 0", cnt, done_pass);
      end
      fill_same();
      m0[7] = 12'h000; m1[7] = 12'hFFF;
      run_seq(12'hFFE, 0, 0, 0, 0);
      n_vec++;
      if (cnt !== 16'd1 || fea !== 8'd7) begin
         n_err++;
         $display("FAIL tol_extreme cnt=%0d addr=%0d want 1 7", cnt, fea);
      end
   endtask

   task automatic test_last_pixel();
      fill_same();
      m1[11] = m0[11] ^ 12'h040;
      run_seq(12'h000, 0, 0, 0, 0);
      n_vec++;
      if (cnt !== 16'd1 || fea !== 8'd11 || frow !== 16'd2 || fcol !== 16'd3 ||
          done_pass !== 1'b0) begin
         n_err++;
         $display("FAIL last_pixel cnt=%0d addr=%0d row=%0d col=%0d pass=%b want 1 11 2 3 0",
                  cnt, fea, frow, fcol, done_pass);
      end
      m1[3] = m0[3] ^ 12'h001;
      run_seq(12'h000, 0, 0, 0, 0);
      n_vec++;
      if (cnt !== 16'd2 || fea !== 8'd3 || frow !== 16'd0 || fcol !== 16'd3) begin
         n_err++;
         $display("FAIL multi_err cnt=%0d addr=%0d row=%0d col=%0d want 2 3 0 3",
                  cnt, fea, frow, fcol);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < N; i++) begin
         m0[i] = DW'($urandom);
         m1[i] = m0[i] ^ 12'h800;
      end
      run_seq(12'h000, 0, 0, 0, 0);
      n_vec++;
      if (cnt_s !== 2'd3 || done_pass_s !== 1'b0 || cnt !== 16'd12) begin
         n_err++;
         $display("FAIL saturate cnt_s=%0d pass_s=%b cnt=%0d want 3 0 12",
                  cnt_s, done_pass_s, cnt);
      end
   endtask

   task automatic test_control();
      fill_same();
      m1[2] = m0[2] ^ 12'h010;
      run_seq(12'h000, 0, 5, 0, 0);
      n_vec++;
      if (done_cyc !== 14 || n_done !== 1 || cnt !== 16'd1) begin
         n_err++;
         $display("FAIL start_midrun done=%0d pulses=%0d cnt=%0d want 14 1 1",
                  done_cyc, n_done, cnt);
      end
      run_seq(12'h000, 0, 14, 0, 0);
      n_vec++;
      if (obs_busy[15] !== 1'b0 || n_done !== 1) begin
         n_err++;
         $display("FAIL start_in_done busy15=%b pulses=%0d want 0 1", obs_busy[15], n_done);
      end
      m1[8] = m0[8] ^ 12'h010;
      run_seq(12'h000, 6, 0, 0, 0);
      n_vec++;
      if (obs_busy[7] !== 1'b0 || obs_en[7] !== 1'b0 || n_done !== 0) begin
         n_err++;
         $display("FAIL abort_idle busy7=%b en7=%b pulses=%0d want 0 0 0",
                  obs_busy[7], obs_en[7], n_done);
      end
      n_vec++;
      if (cnt !== 16'd1 || fev !== 1'b1 || fea !== 8'd2 || pass !== 1'b0) begin
         n_err++;
         $display("FAIL abort_hold cnt=%0d fev=%b addr=%0d pass=%b want 1 1 2 0",
                  cnt, fev, fea, pass);
      end
      fill_same();
      m1[1] = m0[1] ^ 12'h020;
      run_seq(12'h000, 0, 0, 5, 0);
      n_vec++;
      if (obs_cnt[5] !== 1 || obs_fev[5] !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre cnt=%0d fev=%b want 1 1", obs_cnt[5], obs_fev[5]);
      end
      n_vec++;
      if (obs_cnt[6] !== 0 || obs_fev[6] !== 1'b0 || obs_busy[6] !== 1'b0 ||
          obs_en[6] !== 1'b0 || obs_addr[6] !== 0 || n_done !== 0) begin
         n_err++;
         $display("FAIL rst_midrun cnt=%0d fev=%b busy=%b en=%b addr=%0d pulses=%0d want all 0",
                  obs_cnt[6], obs_fev[6], obs_busy[6], obs_en[6], obs_addr[6], n_done);
      end
      n_vec++;
      if ({pass, fev, fea, frow, fcol, cnt} !== '0) begin
         n_err++;
         $display("FAIL rst_outputs pass=%b fev=%b fea=%0d cnt=%0d want 0", pass, fev, fea, cnt);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] t;
      for (int r = 0; r < 15; r++) begin
         for (int i = 0; i < N; i++) begin
            int v;
            m0[i] = DW'($urandom);
            v = int'(m0[i]) + int'($urandom_range(0, 160)) - 80;
            if (v < 0) v = 0;
            if (v > 4095) v = 4095;
            case ($urandom_range(0, 3))
               0: m1[i] = m0[i];
               1: m1[i] = DW'($urandom);
               default: m1[i] = DW'(v);
            endcase
         end
         t = ($urandom_range(0, 3) == 0) ? 12'h000 : DW'($urandom_range(0, 64));
         model(t);
         run_seq(t, 0, 0, 0, 1);
         n_vec++;
         if (int'(cnt) !== e_cnt || int'(cnt_s) !== e_cnt_s) begin
            n_err++;
            $display("FAIL rand%0d_cnt got %0d/%0d want %0d/%0d",
                     r, cnt, cnt_s, e_cnt, e_cnt_s);
         end
         n_vec++;
         if (fev !== e_fev || int'(fea) !== e_fea || int'(frow) !== e_row ||
             int'(fcol) !== e_col) begin
            n_err++;
            $display("FAIL rand%0d_first got %b %0d %0d %0d want %b %0d %0d %0d",
                     r, fev, fea, frow, fcol, e_fev, e_fea, e_row, e_col);
         end
         n_vec++;
         if (done_cyc !== 14 || done_pass !== (e_cnt == 0) || pass !== (e_cnt == 0)) begin
            n_err++;
            $display("FAIL rand%0d_done cyc=%0d pass=%b want 14 %b",
                     r, done_cyc, done_pass, (e_cnt == 0));
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; tol = '0;
      mif.mem0_dout = '0; mif.mem1_dout = '0;
      mif_s.mem0_dout = '0; mif_s.mem1_dout = '0;
      test_reset();
      test_identical();
      test_single();
      test_tolerance();
      test_last_pixel();
      test_saturation();
      test_control();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
